// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the byte/word RAM access sequencer.
package mem_access_unit_pkg;

    localparam int ADDR_W = 8;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Turns byte/word load-store requests into one or two single-port RAM byte
// cycles, absorbs the RAM's registered read latency and returns a response.
module mem_access_unit #(
    parameter int ADDR_W     = mem_access_unit_pkg::ADDR_W,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic                                    req_we,
    input  logic                                    req_word,
    input  logic [ADDR_W-1:0]                       req_addr,
    input  logic [mem_access_unit_pkg::WORD_W-1:0]  req_wdata,
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [mem_access_unit_pkg::WORD_W-1:0]  rsp_rdata,
    output logic                                    busy,
    output logic                                    ram_we,
    output logic [ADDR_W-1:0]                       ram_addr,
    output logic [mem_access_unit_pkg::BYTE_W-1:0]  ram_wdata,
    input  logic [mem_access_unit_pkg::BYTE_W-1:0]  ram_rdata
);
    import mem_access_unit_pkg::*;

    state_t              state, state_nxt;
    logic                we_q, we_nxt;
    logic                word_q, word_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [BYTE_W-1:0]   byte1_q, byte1_nxt;
    logic                ram_we_nxt;
    logic [ADDR_W-1:0]   ram_addr_nxt;
    logic [BYTE_W-1:0]   ram_wdata_nxt;
    logic                rsp_valid_nxt;
    logic [WORD_W-1:0]   rsp_rdata_nxt;

    assign req_ready = (state == IDLE);
    assign busy      = !req_ready;

    always_comb begin
        state_nxt     = state;
        we_nxt        = we_q;
        word_nxt      = word_q;
        addr_nxt      = addr_q;
        byte1_nxt     = byte1_q;
        ram_we_nxt    = ram_we;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    we_nxt        = req_we;
                    word_nxt      = req_word;
                    addr_nxt      = req_addr;
                    ram_addr_nxt  = req_addr;
                    ram_we_nxt    = req_we;
                    ram_wdata_nxt = (req_word && BIG_ENDIAN) ? req_wdata[15:8] : req_wdata[7:0];
                    byte1_nxt     = BIG_ENDIAN ? req_wdata[7:0] : req_wdata[15:8];
                    rsp_rdata_nxt = '0;
                    state_nxt     = B0;
                end
            end
            B0: begin
                if (word_q) begin
                    // Address wraps naturally at the top of the RAM.
                    ram_addr_nxt  = addr_q + ADDR_W'(1);
                    ram_wdata_nxt = byte1_q;
                    state_nxt     = B1;
                end else begin
                    ram_we_nxt    = 1'b0;
                    state_nxt     = we_q ? RESP : CAPT;
                    rsp_valid_nxt = we_q;
                end
            end
            B1: begin
                if (!we_q) begin
                    if (BIG_ENDIAN) rsp_rdata_nxt[15:8] = ram_rdata;
                    else            rsp_rdata_nxt[7:0]  = ram_rdata;
                end
                ram_we_nxt    = 1'b0;
                state_nxt     = we_q ? RESP : CAPT;
                rsp_valid_nxt = we_q;
            end
            CAPT: begin
                if (!word_q)         rsp_rdata_nxt       = {8'h00, ram_rdata};
                else if (BIG_ENDIAN) rsp_rdata_nxt[7:0]  = ram_rdata;
                else                 rsp_rdata_nxt[15:8] = ram_rdata;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                ram_we_nxt    = 1'b0;
                rsp_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            word_q    <= 1'b0;
            addr_q    <= '0;
            byte1_q   <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            we_q      <= we_nxt;
            word_q    <= word_nxt;
            addr_q    <= addr_nxt;
            byte1_q   <= byte1_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: little- and big-endian instances share one
// request stream, each backed by its own behavioural 256-byte RAM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_word, rsp_ready;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;

    logic        req_ready0, rsp_valid0, busy0, ram_we0;
    logic        req_ready1, rsp_valid1, busy1, ram_we1;
    logic [15:0] rsp_rdata0, rsp_rdata1;
    logic [7:0]  ram_addr0, ram_wdata0, ram_rdata0;
    logic [7:0]  ram_addr1, ram_wdata1, ram_rdata1;

    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          we_cnt0  = 0;
    int          we_cnt1  = 0;
    int          viol     = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
        .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
        .busy(busy0), .ram_we(ram_we0), .ram_addr(ram_addr0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
    );

    mem_access_unit #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
        .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
        .busy(busy1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    always @(posedge clk) begin
        if (ram_we0) mem0[ram_addr0] <= ram_wdata0;
        ram_rdata0 <= mem0[ram_addr0];
        if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
        ram_rdata1 <= mem1[ram_addr1];
    end

    // Write pulses are counted per cycle; a strobe while idle or responding is illegal.
    always @(negedge clk) begin
        if (ram_we0) we_cnt0 <= we_cnt0 + 1;
        if (ram_we1) we_cnt1 <= we_cnt1 + 1;
        if ((ram_we0 && (req_ready0 || rsp_valid0)) || (ram_we1 && (req_ready1 || rsp_valid1)))
            viol <= viol + 1;
    end

    // One full transaction with rsp_ready held high; called at a negedge.
    task automatic req_txn(input logic we, input logic word, input logic [7:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rdata,
                           input string name);
        int exp_lat, exp_we, w0, w1, lat;
        logic [15:0] exp;
        exp_lat = we ? (word ? 3 : 2) : (word ? 4 : 3);
        exp_we  = we ? (word ? 2 : 1) : 0;
        w0 = we_cnt0;
        w1 = we_cnt1;
        n_checks++;
        if (req_ready0 !== 1'b1 || req_ready1 !== 1'b1)
            $display("FAIL %s ready_before: got %b/%b want 1", name, req_ready0, req_ready1);
        else n_pass++;
        req_valid = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wdata;
        exp_q.push_back(exp_rdata);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (rsp_valid0 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== exp_lat || rsp_valid1 !== 1'b1)
            $display("FAIL %s latency: got %0d (be valid %b) want %0d", name, lat, rsp_valid1, exp_lat);
        else n_pass++;
        n_checks++;
        if (rsp_rdata0 !== exp)
            $display("FAIL %s rdata_le: got %h want %h", name, rsp_rdata0, exp);
        else n_pass++;
        n_checks++;
        if (rsp_rdata1 !== exp)
            $display("FAIL %s rdata_be: got %h want %h", name, rsp_rdata1, exp);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0 || req_ready0 !== 1'b1 || req_ready1 !== 1'b1)
            $display("FAIL %s idle_after: got valid %b/%b ready %b/%b want 0/0 1/1", name,
                     rsp_valid0, rsp_valid1, req_ready0, req_ready1);
        else n_pass++;
        n_checks++;
        if (we_cnt0 - w0 !== exp_we || we_cnt1 - w1 !== exp_we)
            $display("FAIL %s we_pulses: got %0d/%0d want %0d", name, we_cnt0 - w0, we_cnt1 - w1, exp_we);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ram_we0, ram_addr0, ram_wdata0, rsp_valid0, rsp_rdata0} !== '0 ||
            {ram_we1, ram_addr1, ram_wdata1, rsp_valid1, rsp_rdata1} !== '0)
            $display("FAIL reset_outputs: got we %b addr %h wd %h v %b rd %h want all 0",
                     ram_we0, ram_addr0, ram_wdata0, rsp_valid0, rsp_rdata0);
        else n_pass++;
        n_checks++;
        if (req_ready0 !== 1'b1 || busy0 !== 1'b0 || req_ready1 !== 1'b1 || busy1 !== 1'b0)
            $display("FAIL reset_ready: got ready %b busy %b want 1 0", req_ready0, busy0);
        else n_pass++;
    endtask

    task automatic test_byte();
        req_txn(1'b1, 1'b0, 8'h10, 16'h77A5, 16'h0000, "byte_store");
        n_checks++;
        if (mem0[8'h10] !== 8'hA5 || mem1[8'h10] !== 8'hA5)
            $display("FAIL byte_store_ram: got %h/%h want a5", mem0[8'h10], mem1[8'h10]);
        else n_pass++;
        req_txn(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, "byte_load");
    endtask

    task automatic test_word();
        req_txn(1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, "word_store");
        n_checks++;
        if (mem0[8'h20] !== 8'hEF || mem0[8'h21] !== 8'hBE)
            $display("FAIL word_store_le: got %h %h want ef be", mem0[8'h20], mem0[8'h21]);
        else n_pass++;
        n_checks++;
        if (mem1[8'h20] !== 8'hBE || mem1[8'h21] !== 8'hEF)
            $display("FAIL word_store_be: got %h %h want be ef", mem1[8'h20], mem1[8'h21]);
        else n_pass++;
        req_txn(1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF, "word_load");
    endtask

    task automatic test_wrap();
        req_txn(1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, "wrap_store");
        n_checks++;
        if (mem0[8'hFF] !== 8'h34 || mem0[8'h00] !== 8'h12)
            $display("FAIL wrap_le: got %h %h want 34 12", mem0[8'hFF], mem0[8'h00]);
        else n_pass++;
        n_checks++;
        if (mem1[8'hFF] !== 8'h12 || mem1[8'h00] !== 8'h34)
            $display("FAIL wrap_be: got %h %h want 12 34", mem1[8'hFF], mem1[8'h00]);
        else n_pass++;
        req_txn(1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, "wrap_load");
    endtask

    task automatic test_backpressure();
        int lat, w0, w1;
        logic [15:0] exp;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_word = 1'b1; req_addr = 8'h20; req_wdata = '0;
        exp_q.push_back(16'hBEEF);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (rsp_valid0 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        w0 = we_cnt0;
        w1 = we_cnt1;
        for (int i = 0; i < 5; i++) begin
            // A store request while busy must be ignored.
            req_valid = 1'b1; req_we = 1'b1; req_word = 1'b0; req_addr = 8'h55; req_wdata = 16'h0011;
            n_checks++;
            if (rsp_valid0 !== 1'b1 || rsp_valid1 !== 1'b1 || rsp_rdata0 !== exp || rsp_rdata1 !== exp)
                $display("FAIL bp_hold[%0d]: got valid %b/%b rdata %h/%h want 1 %h",
                         i, rsp_valid0, rsp_valid1, rsp_rdata0, rsp_rdata1, exp);
            else n_pass++;
            n_checks++;
            if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0 || busy0 !== 1'b1)
                $display("FAIL bp_ready[%0d]: got %b/%b busy %b want 0 0 1", i, req_ready0, req_ready1, busy0);
            else n_pass++;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++;
        if (we_cnt0 !== w0 || we_cnt1 !== w1 || mem0[8'h55] === 8'h11)
            $display("FAIL bp_ignored_req: got pulses %0d/%0d want 0", we_cnt0 - w0, we_cnt1 - w1);
        else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready0 !== 1'b1 || req_ready1 !== 1'b1 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0)
            $display("FAIL bp_release: got ready %b/%b valid %b/%b want 1 0",
                     req_ready0, req_ready1, rsp_valid0, rsp_valid1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] snap0, snap1;
        snap0 = mem0[8'h41];
        snap1 = mem1[8'h41];
        req_valid = 1'b1; req_we = 1'b1; req_word = 1'b1; req_addr = 8'h40; req_wdata = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (ram_we0 !== 1'b1 || ram_addr0 !== 8'h40)
            $display("FAIL rst_mid_b0: got we %b addr %h want 1 40", ram_we0, ram_addr0);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (ram_we0 !== 1'b0 || ram_we1 !== 1'b0 || req_ready0 !== 1'b1 || req_ready1 !== 1'b1 ||
            rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0)
            $display("FAIL rst_mid_state: got we %b/%b ready %b/%b valid %b/%b want 0 1 0",
                     ram_we0, ram_we1, req_ready0, req_ready1, rsp_valid0, rsp_valid1);
        else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem0[8'h41] !== snap0 || mem1[8'h41] !== snap1)
            $display("FAIL rst_mid_byte1: got %h/%h want %h/%h", mem0[8'h41], mem1[8'h41], snap0, snap1);
        else n_pass++;
        n_checks++;
        if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0 || exp_q.size() != 0)
            $display("FAIL rst_mid_no_rsp: got valid %b/%b want 0", rsp_valid0, rsp_valid1);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [15:0] d;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 16'($urandom);
            req_txn(1'b1, 1'b1, a, d, 16'h0000, "rand_wstore");
            req_txn(1'b0, 1'b1, a, 16'h0000, d, "rand_wload");
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom);
            req_txn(1'b1, 1'b0, a, {8'($urandom), b}, 16'h0000, "rand_bstore");
            req_txn(1'b0, 1'b0, a, 16'h0000, {8'h00, b}, "rand_bload");
        end
    endtask

    task automatic test_strobe_legal();
        n_checks++;
        if (viol !== 0)
            $display("FAIL we_outside_access: got %0d cycles want 0", viol);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_byte();
        test_word();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_strobe_legal();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
